alu_share_arbiter: RTL

//  Shares one instance of the pipeline's 32-bit alu between two requesters, e.g. the EX-stage
//  and a multi-cycle helper unit. Each requester uses a valid/ready request channel and a

---
 rtl/alu_share_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one 32-bit ALU between two requesters. Each requester has a
//   valid/ready request channel (a, b, op) and a valid/ready response channel
//   (registered result + zero flag). One operation is in flight at a time; a
//   new op may issue in the same cycle the pending response is consumed.
//
// Parameters
//   PRIO_MODE  0 = round-robin, 1 = fixed priority (req0) with anti-starvation
//   MAX_WAIT   PRIO_MODE=1: lost cycles after which req1 is forced to win (>=1)
//
// Ports
//   clk, resetn                         clock, async active-low reset
//   reqN_valid/ready, reqN_a/b/op       request channel of requester N
//   rspN_valid/ready, rspN_result/zero  response channel of requester N
module alu_share_arbiter #(
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero
);

  localparam int unsigned WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP0 = 2'd1,
    RESP1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   res0_q, res0_d, res1_q, res1_d;
  logic          zero0_q, zero0_d, zero1_q, zero1_d;

  logic          can_issue;
  logic          win1;
  logic          acc0, acc1;
  logic [2:0]    alu_op;
  logic [31:0]   alu_a, alu_b, alu_res;

  function automatic logic [31:0] alu_f(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'b010:  r = a + b;
      3'b110:  r = a - b;
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b100:  r = ~a;
      3'b111:  r = {31'b0, (a < b)};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Arbitration and accept: depends only on valids, rsp_ready and state, so
  // there is no path from operands to any ready. Held in reset so no op is
  // accepted while resetn is low.
  always_comb begin
    can_issue = resetn & ((state_q == IDLE) ||
                          ((state_q == RESP0) && rsp0_ready) ||
                          ((state_q == RESP1) && rsp1_ready));
    if (PRIO_MODE == 0) begin
      // Tie goes to the requester that was not granted last.
      win1 = req1_valid & (~req0_valid | ~last_grant_q);
    end else begin
      win1 = req1_valid & (~req0_valid | (wait_cnt_q == WAIT_MAX));
    end
    req0_ready = can_issue & req0_valid & ~win1;
    req1_ready = can_issue & win1;
    acc0 = req0_ready;
    acc1 = req1_ready;
  end

  always_comb begin
    alu_op  = win1 ? req1_op : req0_op;
    alu_a   = win1 ? req1_a  : req0_a;
    alu_b   = win1 ? req1_b  : req0_b;
    alu_res = alu_f(alu_op, alu_a, alu_b);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    res0_d       = res0_q;
    res1_d       = res1_q;
    zero0_d      = zero0_q;
    zero1_d      = zero1_q;

    if (acc0) begin
      state_d      = RESP0;
      last_grant_d = 1'b0;
      res0_d       = alu_res;
      zero0_d      = (alu_res == '0);
    end else if (acc1) begin
      state_d      = RESP1;
      last_grant_d = 1'b1;
      res1_d       = alu_res;
      zero1_d      = (alu_res == '0);
    end else if (can_issue) begin
      // Response drained (or already idle) and nothing issued.
      state_d = IDLE;
    end

    if (!req1_valid || acc1) begin
      wait_cnt_d = '0;
    end else if (acc0 && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wait_cnt_q   <= '0;
      res0_q       <= '0;
      res1_q       <= '0;
      zero0_q      <= 1'b0;
      zero1_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
      zero0_q      <= zero0_d;
      zero1_q      <= zero1_d;
    end
  end

  assign rsp0_valid  = (state_q == RESP0);
  assign rsp1_valid  = (state_q == RESP1);
  assign rsp0_result = res0_q;
  assign rsp1_result = res1_q;
  assign rsp0_zero   = zero0_q;
  assign rsp1_zero   = zero1_q;

endmodule
